// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of fetch entries; occupancy tracked by a count register,
// pointers wrap modulo DEPTH (power of two).
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_data,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~flush & (~full | do_pop);
    assign count   = count_q;
    assign head    = mem[rd_ptr];

    // When full, a simultaneous pop frees the head slot that the tail now overwrites.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC, instruction-memory address, prefetch buffer and decode handshake.
// Optional halt-on-zero-word behaviour is enabled by FETCH_HALT_ON_ZERO_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0004,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    logic [XLEN-1:0]  fpc;
    logic [XLEN-1:0]  redirect_target;
    fetch_entry_t     buf_head;
    fetch_entry_t     last_head;
    fetch_entry_t     push_entry;
    logic [CNT_W-1:0] buf_count;
    logic             buf_empty;
    logic             buf_full;
    logic             pop;
    logic             can_fetch;
    logic             zero_word;
    logic             push;
    logic             halt_active;

    assign imem_addr       = fpc;
    assign redirect_target = redirect_pc & ~32'h0000_0003;
    assign pop             = ~buf_empty & out_ready;
    assign can_fetch       = ~redirect_valid & ~halt_active & (~buf_full | pop);
    assign push            = can_fetch & ~zero_word;
    assign push_entry      = '{pc: fpc, instr: imem_rdata};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .head      (buf_head),
        .count     (buf_count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    // Redirect outranks sequential fetch; wrap past 0xFFFF_FFFC is silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc <= RESET_PC;
        end else if (redirect_valid) begin
            fpc <= redirect_target;
        end else if (push) begin
            fpc <= fpc + XLEN'(PC_STEP);
        end
    end

    // Remembers the most recent head so the outputs hold it once the buffer drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_head <= '0;
        end else if (!buf_empty) begin
            last_head <= buf_head;
        end
    end

    assign out_valid = (buf_count != '0);
    assign out_instr = buf_empty ? last_head.instr : buf_head.instr;
    assign out_pc    = buf_empty ? last_head.pc    : buf_head.pc;

`ifdef FETCH_HALT_ON_ZERO_EN
    fetch_state_e state_q;
    fetch_state_e state_d;

    assign zero_word   = (imem_rdata == '0);
    assign halt_active = (state_q == ST_HALT);
    assign halted      = halt_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero word that would otherwise have been pushed stops fetch until a redirect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (can_fetch && zero_word) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end
`else
    assign zero_word   = 1'b0;
    assign halt_active = 1'b0;
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit against a queue-based
// model of the fetch stream; honours FETCH_HALT_ON_ZERO_EN when defined.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0004;
    localparam int          DEPTH    = 2;
`ifdef FETCH_HALT_ON_ZERO_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    int   n_tests;
    int   n_fail;
    int   n_deliv;
    bit   checking;

    ent_t        mq[$];
    logic [31:0] m_fpc;
    ent_t        m_last;
    bit          m_halt;

    instruction_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0004: return 32'h0020_81B3;
            32'h0000_0008: return 32'h4030_8233;
            32'h0000_0028: return 32'h0000_0000;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer contents as a queue, advanced at each rising edge.
    initial begin
        logic [31:0] w;
        m_fpc  = RESET_PC;
        m_last = '0;
        m_halt = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_fpc  = RESET_PC;
                m_last = '0;
                m_halt = 1'b0;
            end else if (redirect_valid) begin
                mq.delete();
                m_fpc  = {redirect_pc[31:2], 2'b00};
                m_halt = 1'b0;
            end else if (!m_halt && mq.size() < DEPTH) begin
                w = mem_word(m_fpc);
                if (HALT_EN && w == 32'h0) begin
                    m_halt = 1'b1;
                end else begin
                    mq.push_back('{pc: m_fpc, instr: w});
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and retires accepted entries.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (checking) begin
                check("imem_addr", imem_addr, m_fpc);
                check("halted", 32'(halted), 32'(m_halt));
                check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
                if (mq.size() != 0) begin
                    check("out_pc", out_pc, mq[0].pc);
                    check("out_instr", out_instr, mq[0].instr);
                    m_last = mq[0];
                    if (out_ready) begin
                        e = mq.pop_front();
                        n_deliv++;
                    end
                end else begin
                    check("idle_pc", out_pc, m_last.pc);
                    check("idle_instr", out_instr, m_last.instr);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int r;
        n_tests        = 0;
        n_fail         = 0;
        n_deliv        = 0;
        checking       = 1'b0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        tick();
        checking = 1'b1;
        tick();

        rst       = 1'b0;
        out_ready = 1'b1;
        tick(4);

        out_ready = 1'b0;
        tick(5);
        out_ready = 1'b1;
        tick(6);

        out_ready = 1'b0;
        tick(3);
        redirect(32'h0000_0023);
        tick(2);
        out_ready = 1'b1;
        tick(3);

        redirect(32'hFFFF_FFFC);
        tick(4);

        out_ready = 1'b0;
        tick(3);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        tick(3);

        redirect(32'h0000_001C);
        tick(8);
        redirect(32'h0000_0004);
        tick(4);

        for (int i = 0; i < 3000; i++) begin
            out_ready      = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 16) == 0;
            r = int'($urandom % 4);
            case (r)
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFF0 | ($urandom % 16);
                2:       redirect_pc = 32'h0000_0018 | ($urandom % 8);
                default: redirect_pc = RESET_PC;
            endcase
            rst = ($urandom % 200) == 0;
            tick();
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick(4);
        checking = 1'b0;

        n_tests++;
        if (n_deliv < 500) begin
            n_fail++;
            $display("FAIL deliveries: got %0d expected at least 500", n_deliv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the fetch PC and drives the word address into the combinational-read instruction memory.
- Captures each returned 32-bit instruction with its PC into a small prefetch buffer, then presents it to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with buffer flush.

Parameters:
- RESET_PC, 32'h0000_0004, fetch PC loaded on reset; bits [1:0] must be 0.
- BUF_DEPTH, 2, prefetch buffer entries; power of two, range 2..8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- imem_addr  output  32  byte address to instruction memory; memory indexes with addr[31:2].
- imem_rdata  input  32  instruction word, valid combinationally in the same cycle as imem_addr.
- redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (forced to 0).
- out_valid  output  1  buffer head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  head instruction word.
- out_pc  output  32  PC of the head instruction.
- halted  output  1  fetch stopped (optional feature only; otherwise tied to 0).

Behaviour:
- Fetch PC register
  - fpc is a register; imem_addr = fpc combinationally.
  - Reset: fpc = RESET_PC; buffer count = 0; out_valid = 0; out_instr = 0; out_pc = 0; halted = 0.
  - Reset mid-operation discards all buffered entries and any pending redirect in the same cycle.
- Handshakes
  - pop = out_valid & out_ready.
  - push = !redirect_valid & !halted & (count < BUF_DEPTH | pop).
  - Push writes {fpc, imem_rdata} at the tail and sets fpc <= fpc + 4.
  - Full with pop in the same cycle: pop and push both occur; count unchanged.
  - Empty: out_valid = 0. Entries are registered, so no same-cycle bypass: earliest out_valid is the cycle after the first push.
  - Latency from fpc presented to out_valid is 1 cycle.
- Redirect
  - Flushes all entries (count <= 0) and sets fpc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle; a pop in the same cycle is still honoured on the current head, then discarded by the flush.
  - Redirect has priority over push.
- Arithmetic and stability
  - fpc + 4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
  - out_instr and out_pc hold stable while out_valid = 1 and out_ready = 0.
  - When count = 0, out_instr and out_pc show the last head, or 0 after reset.
- States (per cycle): RUN, or HALT (optional feature only).
  - RUN -> HALT per the optional feature.
  - HALT -> RUN on redirect_valid.
  - Any state -> RUN with fpc = RESET_PC on rst.

Optional Feature:
- Macro: FETCH_HALT_ON_ZERO_EN.
- Defined:
  - A fetched word equal to 32'h0 (unpopulated memory) is not pushed.
  - fpc holds; halted <= 1 the next cycle; fetching stops.
  - Already-buffered entries still drain.
  - redirect_valid clears halted and resumes at the target.
- Not defined:
  - 32'h0 is pushed like any other instruction.
  - halted is constant 0 and no HALT state exists.

Decomposition:
- Package fetch_pkg:
  - XLEN = 32.
  - PC_STEP = 4.
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
- Sub-module fetch_buffer:
  - Synchronous FIFO of fetch_entry_t, BUF_DEPTH entries.
  - push/pop/flush inputs; count, empty and full outputs; head output.
  - Occupancy is tracked by a count register; pointers wrap modulo BUF_DEPTH.

Test Plan:
- Reset release, memory words at 0x4 = 0x002081B3 and 0x8 = 0x40308233, out_ready = 1 -> first out_valid cycle gives pc 0x4 / instr 0x002081B3; next cycle gives pc 0x8 / instr 0x40308233.
- out_ready = 0 for 5 cycles -> count saturates at 2; fpc = RESET_PC + 8; head held at pc 0x4. Raise out_ready -> in-order drain with no gap or duplicate.
- redirect_valid with redirect_pc = 0x0000_0023 while full -> buffer empty next cycle; fpc = 0x20; next valid entry has pc 0x20.
- Set fpc via redirect to 0xFFFF_FFFC -> entries for pc 0xFFFF_FFFC then 0x0000_0000.
- rst asserted while 2 entries are buffered -> next cycle out_valid = 0 and fpc = RESET_PC.
- With FETCH_HALT_ON_ZERO_EN, fetch reaches a 32'h0 word at 0x28 -> 0x28 is not delivered, halted = 1, fpc stays 0x28; redirect to 0x4 -> halted = 0 and fetch resumes.
